// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates cfg_len consecutive signed psums into one saturating
//   dot-product result. The result is handed downstream over valid/ready.
//   Ports:
//     clk, rst              clock and synchronous active-high reset
//     start, cfg_len        begin an accumulation of cfg_len beats (IDLE only)
//     psum_in, in_valid     incoming signed partial sum stream
//     in_ready              beats are accepted (high only while accumulating)
//     out_data, out_sat     result and sticky saturation flag
//     out_valid, out_ready  result handshake
//     busy                  an accumulation or result hand-off is in progress
module psum_accumulator #(
  parameter int unsigned PSUM_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned EXT_W = SUM_W - PSUM_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              sat_q, sat_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              beat;
  logic              last_beat;
  logic [SUM_W-1:0]  sum;
  logic              sat_hit;
  logic [ACC_W-1:0]  acc_next;

  // Beat qualification against the latched length
  assign beat      = in_valid && in_ready_q;
  assign last_beat = (cnt_q == LEN_W'(len_q - LEN_W'(1)));

  // One guard bit above the accumulator: overflow shows as the top two bits differing
  assign sum      = {acc_q[ACC_W-1], acc_q} + {{EXT_W{psum_in[PSUM_W-1]}}, psum_in};
  assign sat_hit  = (sum[SUM_W-1] != sum[SUM_W-2]);
  assign acc_next = sat_hit ? (sum[SUM_W-1] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

  // State register and all datapath/output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (cfg_len != '0)) state_d = S_ACCUM;
      S_ACCUM: if (beat && last_beat)        state_d = S_HOLD;
      S_HOLD:  if (out_valid_q && out_ready) state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (state_d == S_ACCUM) begin
          len_d = cfg_len;
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = acc_next;
          sat_d = sat_q | sat_hit;
          cnt_d = LEN_W'(cnt_q + LEN_W'(1));
          if (last_beat) begin
            out_data_d  = acc_next;
            out_sat_d   = sat_q | sat_hit;
            out_valid_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase

    // Status flags follow the state being entered so they line up with it
    in_ready_d = (state_d == S_ACCUM);
    busy_d     = (state_d != S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: two instances (32-bit and 18-bit accumulators)
// share one stimulus stream; expected results are queued per instance and a
// negedge monitor pops and compares on every completed handshake.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic [15:0] psum_in;
  logic        in_valid;
  logic        out_ready;

  logic        a_in_ready, a_out_sat, a_out_valid, a_busy;
  logic [31:0] a_out_data;
  logic        b_in_ready, b_out_sat, b_out_valid, b_busy;
  logic [17:0] b_out_data;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.PSUM_W(16), .ACC_W(32), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .psum_in(psum_in),
    .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .out_valid(a_out_valid), .out_ready(out_ready), .busy(a_busy)
  );

  psum_accumulator #(.PSUM_W(16), .ACC_W(18), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .psum_in(psum_in),
    .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .out_valid(b_out_valid), .out_ready(out_ready), .busy(b_busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input longint da, input bit sa, input longint db, input bit sb);
    exp_t e;
    e.data = da; e.sat = sa; q_a.push_back(e);
    e.data = db; e.sat = sb; q_b.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input logic [15:0] v);
    psum_in  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    psum_in  = 16'h0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: compares every accepted result against the queues
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_out_valid && out_ready) begin
      if (q_a.size() == 0) begin
        check("unexpected_result_a", 1, 0);
      end else begin
        e = q_a.pop_front();
        check("result_data_a", $signed(a_out_data), e.data);
        check("result_sat_a", a_out_sat, e.sat);
      end
    end
    if (!rst && b_out_valid && out_ready) begin
      if (q_b.size() == 0) begin
        check("unexpected_result_b", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("result_data_b", $signed(b_out_data), e.data);
        check("result_sat_b", b_out_sat, e.sat);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = 8'd0; psum_in = 16'h0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_out_data", a_out_data, 0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_in_ready", a_in_ready, 0);
    check("reset_busy", a_busy, 0);
    check("reset_out_sat", a_out_sat, 0);

    // 1: len 4, back-to-back beats; cfg_len change while busy must not matter
    expect_result(10, 0, 10, 0);
    do_start(8'd4);
    cfg_len = 8'd2;
    check("t1_in_ready", a_in_ready, 1);
    check("t1_busy", a_busy, 1);
    beat(16'd1); beat(16'd2); beat(16'd3);
    check("t1_no_early_valid", a_out_valid, 0);
    beat(16'd4);
    check("t1_valid_after_last", a_out_valid, 1);
    check("t1_in_ready_hold", a_in_ready, 0);
    tick();
    check("t1_valid_one_cycle", a_out_valid, 0);
    check("t1_idle_busy", a_busy, 0);

    // 2: len 3 with gaps; count only advances on valid beats
    expect_result(-32766, 0, -32766, 0);
    do_start(8'd3);
    beat(16'hFFFB);
    gap(2);
    beat(16'h8000);
    gap(3);
    check("t2_still_accum", a_in_ready, 1);
    check("t2_no_valid_yet", a_out_valid, 0);
    beat(16'd7);
    check("t2_valid", a_out_valid, 1);
    tick();
    check("t2_done", a_busy, 0);

    // 3: downstream stall holds the result; start during HOLD is ignored
    out_ready = 1'b0;
    expect_result(300, 0, 300, 0);
    do_start(8'd2);
    beat(16'd100);
    beat(16'd200);
    start = 1'b1; cfg_len = 8'd7;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", a_out_valid, 1);
      check("t3_hold_data", $signed(a_out_data), 300);
      check("t3_hold_in_ready", a_in_ready, 0);
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_release_busy", a_busy, 0);
    check("t3_release_valid", a_out_valid, 0);
    tick();
    check("t3_start_ignored", a_busy, 0);

    // 4: saturation (18-bit instance clips, 32-bit instance does not)
    expect_result(163835, 0, 131071, 1);
    do_start(8'd5);
    for (int i = 0; i < 5; i++) beat(16'h7FFF);
    check("t4_pos_sat_b", b_out_sat, 1);
    tick();
    expect_result(-163840, 0, -131072, 1);
    do_start(8'd5);
    for (int i = 0; i < 5; i++) beat(16'h8000);
    check("t4_neg_data_b", $signed(b_out_data), -131072);
    tick();

    // 5: reset mid-accumulation discards the partial sum
    do_start(8'd4);
    beat(16'd50);
    beat(16'd60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_in_ready", a_in_ready, 0);
    check("t5_rst_out_valid", a_out_valid, 0);
    check("t5_rst_out_data", a_out_data, 0);
    expect_result(9, 0, 9, 0);
    do_start(8'd1);
    beat(16'd9);
    check("t5_len1_valid", a_out_valid, 1);
    tick();

    // 6: zero length is ignored, then len 1 starts normally
    do_start(8'd0);
    check("t6_zero_busy", a_busy, 0);
    check("t6_zero_in_ready", a_in_ready, 0);
    expect_result(-3, 0, -3, 0);
    do_start(8'd1);
    check("t6_accum_in_ready", a_in_ready, 1);
    check("t6_accum_busy", a_busy, 1);
    beat(16'hFFFD);
    tick();
    tick();

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
